chroma_key_ctrl: RTL and testbench
==================================

CHROMA_KEY_CTRL -- requirements
Module: chroma_key_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- CAL_X0, 280, first calibration column.
- CAL_Y0, 200, first calibration row.
- CAL_W, 80, calibration window width.
- CAL_H, 80, calibration window height.
- CAL_MARGIN, 16, guard band applied to the sampled thresholds.
- KEY_MARGIN, 40, minimum G lead over R and B required by the mixer.
- RST_G_MIN, 128, reset value of G_min.
- RST_RG_MAX, 96, reset value of RG_max.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst, in, 1, synchronous, active-high reset.
- frame_start, in, 1, one-cycle pulse before the first pixel of a frame.
- i_pixel_valid, in, 1, camera pixel strobe.
- rgb_data, in, 16, camera pixel {4'b0000,R[3:0],G[3:0],B[3:0]}.
- cfg_g_min, in, 8, host G_min value.
- cfg_rg_max, in, 8, host RG_max value.
- cfg_wr, in, 1, one-cycle host write strobe.
- cal_req, in, 1, one-cycle calibration request.
- G_min, out, 8, active threshold to the mixer.
- RG_max, out, 8, active threshold to the mixer.
- cal_busy, out, 1, calibration in progress.
- cal_done, out, 1, one-cycle pulse on calibration success.
- cal_fail, out, 1, sticky calibration failure flag.

REQ-003 The block SHALL use one clock, clk, and one reset, rst; rst is synchronous and active-high.

Function
REQ-004 Each colour channel SHALL be expanded to 8 bits as {nibble,4'b0000}, matching the mixer's expansion.
REQ-005 The block SHALL hold pending_g_min and pending_rg_max. G_min and RG_max SHALL load the pending values only on the cycle after a frame_start, so thresholds never change mid-frame.
REQ-006 cfg_wr SHALL load the pending registers from cfg_g_min and cfg_rg_max when cal_busy=0. cfg_wr SHALL be ignored when cal_busy=1.
REQ-007 If cfg_wr and frame_start coincide, the active registers SHALL take the old pending values, and the new values SHALL apply at the following frame_start.
REQ-008 The FSM SHALL have the states IDLE, WAIT_SOF, SAMPLE, COMPUTE and APPLY. cal_busy=1 in every state except IDLE.
REQ-009 IDLE->WAIT_SOF on cal_req. cal_req received while busy SHALL be ignored.
REQ-010 WAIT_SOF->SAMPLE on frame_start. Entering SAMPLE SHALL clear the x/y counters and set min_g=255, max_r=0, max_b=0.
REQ-011 In SAMPLE, on each i_pixel_valid:
- x increments and wraps at H_ACTIVE-1 to 0, incrementing y.
- If CAL_X0<=x<CAL_X0+CAL_W and CAL_Y0<=y<CAL_Y0+CAL_H, min_g, max_r and max_b update.
REQ-012 SAMPLE->COMPUTE on the last window pixel (x=CAL_X0+CAL_W-1, y=CAL_Y0+CAL_H-1).
REQ-013 A frame_start received in SAMPLE before the window completes SHALL set cal_fail and return the FSM to IDLE with the thresholds unchanged.
REQ-014 COMPUTE, one cycle: let m=max(max_r,max_b).
- new_g = min_g-CAL_MARGIN, saturating at 0.
- new_rg = m+CAL_MARGIN, saturating at 255.
- Arithmetic SHALL use 9-bit intermediates.
REQ-015 COMPUTE SHALL fail if min_g < m+KEY_MARGIN (9-bit compare) or new_g < new_rg. On failure: cal_fail=1, the FSM goes to IDLE and the pending registers are unchanged.
REQ-016 APPLY, one cycle: the pending registers take new_g/new_rg, cal_done pulses, cal_fail clears, and the FSM goes to IDLE. The active thresholds SHALL update at the next frame_start.
REQ-017 cal_fail SHALL remain set until the next successful APPLY or reset. A new cal_req SHALL NOT clear it.
REQ-018 i_pixel_valid outside SAMPLE SHALL have no effect.

Reset
REQ-019 On rst:
- G_min and pending_g_min = RST_G_MIN.
- RG_max and pending_rg_max = RST_RG_MAX.
- The FSM goes to IDLE.
- cal_busy=0, cal_done=0, cal_fail=0.
- The counters and accumulators clear.
REQ-020 An rst asserted mid-calibration SHALL abort the calibration with no partial threshold update.

Structure
REQ-021 The FSM state encoding, the channel expansion width and the RST_* defaults SHALL live in the shared package chroma_key_pkg.
REQ-022 The window min/max tracker SHALL be one sub-module, cal_window_stats, with inputs clear, sample_en and pixel, and outputs min_g, max_r and max_b.

Verification
REQ-023 Reset: assert rst -> G_min=128, RG_max=96, cal_busy=0, cal_fail=0.
REQ-024 Host write: cfg_wr with 150/60 mid-frame -> outputs unchanged until frame_start, then G_min=150 and RG_max=60 one cycle later.
REQ-025 Calibration success: cal_req, then a frame with window pixels R=2, G=14, B=3 -> min_g=224, m=48, cal_done pulse, pending=208/64, active after the next frame_start.
REQ-026 Weak green: window pixel G=8, R=6 -> 128<96+40 -> cal_fail=1 and thresholds unchanged.
REQ-027 Short frame: frame_start at y=100 during SAMPLE -> cal_fail=1, IDLE, no cal_done.
REQ-028 Collisions:
- cfg_wr while busy -> ignored.
- cfg_wr coincident with frame_start -> values apply one frame later.
- rst during SAMPLE -> reset values and IDLE.

Source files
------------

// File: rtl/chroma_key_pkg.sv
// Shared types and constants for the chroma-key threshold controller:
// calibration FSM encoding, channel expansion and threshold reset defaults.
package chroma_key_pkg;

    localparam int CH_W  = 8;
    localparam int NIB_W = 4;

    localparam logic [CH_W-1:0] RST_G_MIN_DEF  = 8'd128;
    localparam logic [CH_W-1:0] RST_RG_MAX_DEF = 8'd96;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_SAMPLE,
        ST_COMPUTE,
        ST_APPLY
    } cal_state_e;

    // Same nibble-to-byte expansion as the mixer, so thresholds compare like-for-like.
    function automatic logic [CH_W-1:0] expand_ch(input logic [NIB_W-1:0] nib);
        return {nib, {(CH_W - NIB_W){1'b0}}};
    endfunction

endpackage

// File: rtl/cal_window_stats.sv
// Running min(G) / max(R) / max(B) over the pixels flagged by sample_en.
// clear re-arms the trackers to their neutral values at the start of a window.
module cal_window_stats
    import chroma_key_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            sample_en,
    input  logic [15:0]     pixel,
    output logic [CH_W-1:0] min_g,
    output logic [CH_W-1:0] max_r,
    output logic [CH_W-1:0] max_b
);

    logic [CH_W-1:0] r_d, g_d, b_d;
    logic [CH_W-1:0] min_g_q, max_r_q, max_b_q;
    logic            unused_pad;

    assign r_d        = expand_ch(pixel[11:8]);
    assign g_d        = expand_ch(pixel[7:4]);
    assign b_d        = expand_ch(pixel[3:0]);
    assign unused_pad = ^pixel[15:12];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            min_g_q <= '1;
            max_r_q <= '0;
            max_b_q <= '0;
        end else if (sample_en) begin
            if (g_d < min_g_q) min_g_q <= g_d;
            if (r_d > max_r_q) max_r_q <= r_d;
            if (b_d > max_b_q) max_b_q <= b_d;
        end
    end

    assign min_g = min_g_q;
    assign max_r = max_r_q;
    assign max_b = max_b_q;

endmodule

// File: rtl/chroma_key_ctrl.sv
// Chroma-key threshold controller: host-written or auto-calibrated G_min/RG_max,
// staged in pending registers and committed to the mixer only at frame boundaries.
module chroma_key_ctrl
    import chroma_key_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CAL_X0     = 280,
    parameter int CAL_Y0     = 200,
    parameter int CAL_W      = 80,
    parameter int CAL_H      = 80,
    parameter int CAL_MARGIN = 16,
    parameter int KEY_MARGIN = 40,
    parameter int RST_G_MIN  = int'(RST_G_MIN_DEF),
    parameter int RST_RG_MAX = int'(RST_RG_MAX_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_start,
    input  logic            i_pixel_valid,
    input  logic [15:0]     rgb_data,
    input  logic [CH_W-1:0] cfg_g_min,
    input  logic [CH_W-1:0] cfg_rg_max,
    input  logic            cfg_wr,
    input  logic            cal_req,
    output logic [CH_W-1:0] G_min,
    output logic [CH_W-1:0] RG_max,
    output logic            cal_busy,
    output logic            cal_done,
    output logic            cal_fail
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [XW-1:0]   X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]   Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [XW-1:0]   WX_LO  = XW'(CAL_X0);
    localparam logic [XW-1:0]   WX_HI  = XW'(CAL_X0 + CAL_W - 1);
    localparam logic [YW-1:0]   WY_LO  = YW'(CAL_Y0);
    localparam logic [YW-1:0]   WY_HI  = YW'(CAL_Y0 + CAL_H - 1);
    localparam logic [CH_W:0]   CAL_MARGIN9 = (CH_W+1)'(CAL_MARGIN);
    localparam logic [CH_W:0]   KEY_MARGIN9 = (CH_W+1)'(KEY_MARGIN);
    localparam logic [CH_W-1:0] RST_G  = CH_W'(RST_G_MIN);
    localparam logic [CH_W-1:0] RST_RG = CH_W'(RST_RG_MAX);

    function automatic logic [CH_W-1:0] sat_sub(input logic [CH_W:0] a, input logic [CH_W:0] b);
        return (a < b) ? '0 : CH_W'(a - b);
    endfunction

    function automatic logic [CH_W-1:0] sat_add(input logic [CH_W:0] a, input logic [CH_W:0] b);
        logic [CH_W:0] s;
        s = a + b;
        return s[CH_W] ? '1 : s[CH_W-1:0];
    endfunction

    cal_state_e      state_q;
    logic            cal_busy_q, cal_done_q, cal_fail_q;
    logic [CH_W-1:0] g_min_q, rg_max_q, pend_g_q, pend_rg_q;
    logic [CH_W-1:0] new_g_q, new_rg_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;

    logic            stats_clear_d, sample_en_d, in_win_d, last_pix_d, cal_ok_d;
    logic [CH_W-1:0] min_g_d, max_r_d, max_b_d, m_d, new_g_d, new_rg_d;

    assign in_win_d      = (x_q >= WX_LO) && (x_q <= WX_HI) && (y_q >= WY_LO) && (y_q <= WY_HI);
    assign last_pix_d    = (x_q == WX_HI) && (y_q == WY_HI);
    assign stats_clear_d = (state_q == ST_WAIT_SOF) && frame_start;
    assign sample_en_d   = (state_q == ST_SAMPLE) && i_pixel_valid && !frame_start && in_win_d;

    cal_window_stats u_stats (
        .clk       (clk),
        .rst       (rst),
        .clear     (stats_clear_d),
        .sample_en (sample_en_d),
        .pixel     (rgb_data),
        .min_g     (min_g_d),
        .max_r     (max_r_d),
        .max_b     (max_b_d)
    );

    // Threshold derivation, evaluated while in COMPUTE; 9-bit so margins cannot wrap.
    always_comb begin
        m_d      = (max_r_d > max_b_d) ? max_r_d : max_b_d;
        new_g_d  = sat_sub({1'b0, min_g_d}, CAL_MARGIN9);
        new_rg_d = sat_add({1'b0, m_d}, CAL_MARGIN9);
        cal_ok_d = !({1'b0, min_g_d} < ({1'b0, m_d} + KEY_MARGIN9)) && !(new_g_d < new_rg_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cal_busy_q <= 1'b0;
            cal_done_q <= 1'b0;
            cal_fail_q <= 1'b0;
            g_min_q    <= RST_G;
            rg_max_q   <= RST_RG;
            pend_g_q   <= RST_G;
            pend_rg_q  <= RST_RG;
            new_g_q    <= '0;
            new_rg_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            cal_done_q <= 1'b0;
            // Active thresholds sample pending at the frame boundary, so a
            // coincident host write only lands in pending for the next frame.
            if (frame_start) begin
                g_min_q  <= pend_g_q;
                rg_max_q <= pend_rg_q;
            end
            if (cfg_wr && !cal_busy_q) begin
                pend_g_q  <= cfg_g_min;
                pend_rg_q <= cfg_rg_max;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cal_req) begin
                        state_q    <= ST_WAIT_SOF;
                        cal_busy_q <= 1'b1;
                    end
                end
                ST_WAIT_SOF: begin
                    if (frame_start) begin
                        state_q <= ST_SAMPLE;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (frame_start) begin
                        cal_fail_q <= 1'b1;
                        cal_busy_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else if (i_pixel_valid) begin
                        if (last_pix_d) state_q <= ST_COMPUTE;
                        if (x_q == X_LAST) begin
                            x_q <= '0;
                            y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                        end else begin
                            x_q <= x_q + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (cal_ok_d) begin
                        new_g_q  <= new_g_d;
                        new_rg_q <= new_rg_d;
                        state_q  <= ST_APPLY;
                    end else begin
                        cal_fail_q <= 1'b1;
                        cal_busy_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_APPLY: begin
                    pend_g_q   <= new_g_q;
                    pend_rg_q  <= new_rg_q;
                    cal_done_q <= 1'b1;
                    cal_fail_q <= 1'b0;
                    cal_busy_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    cal_busy_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign G_min    = g_min_q;
    assign RG_max   = rg_max_q;
    assign cal_busy = cal_busy_q;
    assign cal_done = cal_done_q;
    assign cal_fail = cal_fail_q;

endmodule

// File: tb/tb_chroma_key_ctrl.sv
// Directed bench for chroma_key_ctrl on a reduced 16x12 frame with a 4x4
// calibration window at (4,3); expected values are worked out by hand.
module tb_chroma_key_ctrl;

    localparam int H  = 16;
    localparam int V  = 12;
    localparam int X0 = 4;
    localparam int Y0 = 3;
    localparam int WW = 4;
    localparam int WH = 4;
    localparam logic [15:0] BG = 16'h0F0F;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       frame_start = 1'b0;
    logic       i_pixel_valid = 1'b0;
    logic [15:0] rgb_data = '0;
    logic [7:0] cfg_g_min = '0;
    logic [7:0] cfg_rg_max = '0;
    logic       cfg_wr = 1'b0;
    logic       cal_req = 1'b0;
    logic [7:0] G_min, RG_max;
    logic       cal_busy, cal_done, cal_fail;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int d0;

    chroma_key_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .CAL_X0(X0), .CAL_Y0(Y0), .CAL_W(WW), .CAL_H(WH)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .i_pixel_valid(i_pixel_valid),
        .rgb_data(rgb_data), .cfg_g_min(cfg_g_min), .cfg_rg_max(cfg_rg_max), .cfg_wr(cfg_wr),
        .cal_req(cal_req), .G_min(G_min), .RG_max(RG_max), .cal_busy(cal_busy),
        .cal_done(cal_done), .cal_fail(cal_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cal_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pulse_cal_req();
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
    endtask

    // One frame: frame_start, then `lines` lines of H valid pixels each followed
    // by a non-valid gap cycle carrying a hostile pixel value.
    task automatic send_frame(input logic [15:0] win, input int lines);
        pulse_fs();
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < H; x++) begin
                i_pixel_valid = 1'b1;
                rgb_data = (x >= X0 && x < X0 + WW && y >= Y0 && y < Y0 + WH) ? win : BG;
                tick();
            end
            i_pixel_valid = 1'b0;
            rgb_data = 16'h0F00;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (G_min !== 8'd128) begin errors++; $display("FAIL reset_g_min got %0d want 128", G_min); end
        checks++; if (RG_max !== 8'd96) begin errors++; $display("FAIL reset_rg_max got %0d want 96", RG_max); end
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", cal_busy); end
        checks++; if (cal_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b want 0", cal_fail); end
        checks++; if (cal_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", cal_done); end
    endtask

    task automatic test_host_write();
        cfg_g_min = 8'd150; cfg_rg_max = 8'd60; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        tick(); tick();
        checks++; if (G_min !== 8'd128 || RG_max !== 8'd96) begin errors++; $display("FAIL host_midframe got %0d/%0d want 128/96", G_min, RG_max); end
        pulse_fs();
        checks++; if (G_min !== 8'd150 || RG_max !== 8'd60) begin errors++; $display("FAIL host_after_sof got %0d/%0d want 150/60", G_min, RG_max); end
    endtask

    task automatic test_cal_success();
        d0 = done_cnt;
        pulse_cal_req();
        checks++; if (cal_busy !== 1'b1) begin errors++; $display("FAIL succ_busy got %b want 1", cal_busy); end
        send_frame(16'h02E3, V);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL succ_done_pulses got %0d want 1", done_cnt - d0); end
        checks++; if (cal_busy !== 1'b0 || cal_fail !== 1'b0) begin errors++; $display("FAIL succ_flags got busy=%b fail=%b want 0/0", cal_busy, cal_fail); end
        checks++; if (G_min !== 8'd150 || RG_max !== 8'd60) begin errors++; $display("FAIL succ_before_sof got %0d/%0d want 150/60", G_min, RG_max); end
        pulse_fs();
        checks++; if (G_min !== 8'd208 || RG_max !== 8'd64) begin errors++; $display("FAIL succ_applied got %0d/%0d want 208/64", G_min, RG_max); end
    endtask

    task automatic test_weak_green();
        d0 = done_cnt;
        pulse_cal_req();
        send_frame(16'h0680, V);
        checks++; if (cal_fail !== 1'b1 || cal_busy !== 1'b0) begin errors++; $display("FAIL weak_flags got fail=%b busy=%b want 1/0", cal_fail, cal_busy); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL weak_done got %0d pulses want 0", done_cnt - d0); end
        pulse_fs();
        checks++; if (G_min !== 8'd208 || RG_max !== 8'd64) begin errors++; $display("FAIL weak_thresholds got %0d/%0d want 208/64", G_min, RG_max); end
    endtask

    task automatic test_short_frame();
        d0 = done_cnt;
        pulse_cal_req();
        checks++; if (cal_fail !== 1'b1 || cal_busy !== 1'b1) begin errors++; $display("FAIL short_sticky got fail=%b busy=%b want 1/1", cal_fail, cal_busy); end
        send_frame(16'h02E3, Y0 + 2);
        pulse_fs();
        checks++; if (cal_fail !== 1'b1 || cal_busy !== 1'b0) begin errors++; $display("FAIL short_abort got fail=%b busy=%b want 1/0", cal_fail, cal_busy); end
        tick(); tick(); tick(); tick();
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL short_done got %0d pulses want 0", done_cnt - d0); end
        checks++; if (G_min !== 8'd208 || RG_max !== 8'd64) begin errors++; $display("FAIL short_thresholds got %0d/%0d want 208/64", G_min, RG_max); end
    endtask

    task automatic test_busy_write();
        pulse_cal_req();
        cfg_g_min = 8'd10; cfg_rg_max = 8'd20; cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        send_frame(16'h02E3, 1);
        pulse_fs();
        checks++; if (cal_busy !== 1'b0) begin errors++; $display("FAIL busywr_idle got busy=%b want 0", cal_busy); end
        pulse_fs();
        checks++; if (G_min !== 8'd208 || RG_max !== 8'd64) begin errors++; $display("FAIL busywr_ignored got %0d/%0d want 208/64", G_min, RG_max); end
    endtask

    task automatic test_coincident_write();
        cfg_g_min = 8'd100; cfg_rg_max = 8'd30; cfg_wr = 1'b1; frame_start = 1'b1;
        tick();
        cfg_wr = 1'b0; frame_start = 1'b0;
        checks++; if (G_min !== 8'd208 || RG_max !== 8'd64) begin errors++; $display("FAIL coinc_old got %0d/%0d want 208/64", G_min, RG_max); end
        tick(); tick();
        pulse_fs();
        checks++; if (G_min !== 8'd100 || RG_max !== 8'd30) begin errors++; $display("FAIL coinc_next got %0d/%0d want 100/30", G_min, RG_max); end
    endtask

    task automatic test_fail_clear();
        d0 = done_cnt;
        pulse_cal_req();
        send_frame(16'h01F4, V);
        checks++; if (cal_fail !== 1'b0 || done_cnt - d0 !== 1) begin errors++; $display("FAIL clear_flags got fail=%b done=%0d want 0/1", cal_fail, done_cnt - d0); end
        pulse_fs();
        checks++; if (G_min !== 8'd224 || RG_max !== 8'd80) begin errors++; $display("FAIL clear_applied got %0d/%0d want 224/80", G_min, RG_max); end
    endtask

    task automatic test_rst_mid_sample();
        d0 = done_cnt;
        pulse_cal_req();
        send_frame(16'h02E3, Y0 + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (G_min !== 8'd128 || RG_max !== 8'd96) begin errors++; $display("FAIL rstmid_thr got %0d/%0d want 128/96", G_min, RG_max); end
        checks++; if (cal_busy !== 1'b0 || cal_fail !== 1'b0) begin errors++; $display("FAIL rstmid_flags got busy=%b fail=%b want 0/0", cal_busy, cal_fail); end
        send_frame(16'h02E3, V);
        pulse_fs();
        checks++; if (done_cnt != d0 || cal_busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle got done=%0d busy=%b want 0/0", done_cnt - d0, cal_busy); end
        checks++; if (G_min !== 8'd128 || RG_max !== 8'd96) begin errors++; $display("FAIL rstmid_after got %0d/%0d want 128/96", G_min, RG_max); end
    endtask

    initial begin
        tick();
        test_reset();
        test_host_write();
        test_cal_success();
        test_weak_green();
        test_short_frame();
        test_busy_write();
        test_coincident_write();
        test_fail_clear();
        test_rst_mid_sample();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
